// File: rtl/spi_ram_slave_p.sv
// SPI slave with an on-chip single-port RAM: 2-bit command + DATA_WIDTH payload frames.
// Optional feature macro: SPI_ADDR_AUTOINC_EN (address auto-increment for bursts).
module spi_ram_slave_p #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic cmd_err
);

    localparam int FL  = DATA_WIDTH + 2;
    localparam int CW  = $clog2(FL + 1);
    localparam int MCW = $clog2(DATA_WIDTH + 1);
    localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [CW-1:0]         FL_C    = CW'(FL);
    localparam logic [CW-1:0]         LAST_C  = CW'(FL - 1);
    localparam logic [MCW-1:0]        DW_C    = MCW'(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

    state_t                  state_q, state_d;
    state_t                  fstate_q;
    logic [FL-1:0]           frame_q;
    logic [CW-1:0]           bcnt_q;
    logic                    done_q;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, rd_addr_q;
    logic                    rd_valid_q;
    logic [DATA_WIDTH-1:0]   rdata_q, shreg_q;
    logic                    load_q, shift_q;
    logic [MCW-1:0]          mcnt_q;
    logic                    miso_q, cmd_err_q;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic                    data_st, sample;
    logic [1:0]              cmd;
    logic [DATA_WIDTH-1:0]   pl;
    logic                    do_wa, do_wd, do_ra, do_rd, do_err;
    logic                    wr_in_range, rd_in_range;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state; data states hold until SS_n deasserts
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!SS_n) state_d = CHK_CMD;
            CHK_CMD: begin
                if (SS_n)            state_d = IDLE;
                else if (!MOSI)      state_d = WRITE;
                else if (rd_valid_q) state_d = READ_DATA;
                else                 state_d = READ_ADD;
            end
            default: if (SS_n) state_d = IDLE;
        endcase
    end

    // The last frame bit is still taken when SS_n rises on the same edge
    always_comb begin
        data_st = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);
        sample  = data_st && (bcnt_q != FL_C) && (!SS_n || (bcnt_q == LAST_C));
        cmd     = frame_q[FL-1:FL-2];
        pl      = frame_q[DATA_WIDTH-1:0];
        do_wa   = done_q && (fstate_q == WRITE)     && (cmd == 2'b00);
        do_wd   = done_q && (fstate_q == WRITE)     && (cmd == 2'b01);
        do_ra   = done_q && (fstate_q == READ_ADD)  && (cmd == 2'b10);
        do_rd   = done_q && (fstate_q == READ_DATA) && (cmd == 2'b11);
        do_err  = done_q && !(do_wa || do_wd || do_ra || do_rd);
        wr_in_range = {1'b0, wr_addr_q} < DEPTH_C;
        rd_in_range = {1'b0, rd_addr_q} < DEPTH_C;
    end

`ifdef SPI_ADDR_AUTOINC_EN
    logic [ADDR_WIDTH:0]   wr_sum, rd_sum, wr_mod, rd_mod;
    logic [ADDR_WIDTH-1:0] wr_next, rd_next;

    always_comb begin
        wr_sum  = {1'b0, wr_addr_q} + (ADDR_WIDTH + 1)'(1);
        rd_sum  = {1'b0, rd_addr_q} + (ADDR_WIDTH + 1)'(1);
        wr_mod  = wr_sum % DEPTH_C;
        rd_mod  = rd_sum % DEPTH_C;
        wr_next = wr_mod[ADDR_WIDTH-1:0];
        rd_next = rd_mod[ADDR_WIDTH-1:0];
    end
`endif

    // RAM: not reset; out-of-range writes dropped and reads return zero
    always_ff @(posedge clk) begin
        if (rst_n && do_wd && wr_in_range)
            mem[wr_addr_q[IW-1:0]] <= pl;
        if (do_rd)
            rdata_q <= rd_in_range ? mem[rd_addr_q[IW-1:0]] : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fstate_q   <= IDLE;
            frame_q    <= '0;
            bcnt_q     <= '0;
            done_q     <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            rd_valid_q <= 1'b0;
            shreg_q    <= '0;
            load_q     <= 1'b0;
            shift_q    <= 1'b0;
            mcnt_q     <= '0;
            miso_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            cmd_err_q <= do_err;
            done_q    <= sample && (bcnt_q == LAST_C);

            if (!data_st) begin
                bcnt_q <= '0;
            end else if (sample) begin
                frame_q  <= {frame_q[FL-2:0], MOSI};
                bcnt_q   <= bcnt_q + CW'(1);
                fstate_q <= state_q;
            end

            if (do_wa) wr_addr_q <= pl[ADDR_WIDTH-1:0];
`ifdef SPI_ADDR_AUTOINC_EN
            if (do_wd) wr_addr_q <= wr_next;
`endif
            if (do_ra) begin
                rd_addr_q  <= pl[ADDR_WIDTH-1:0];
                rd_valid_q <= 1'b1;
            end

            // Read return: RAM latency, load, then DATA_WIDTH shift cycles
            load_q <= do_rd;
            if (SS_n) begin
                load_q  <= 1'b0;
                shift_q <= 1'b0;
                mcnt_q  <= '0;
                miso_q  <= 1'b0;
            end else if (load_q) begin
                shreg_q <= rdata_q;
                shift_q <= 1'b1;
                mcnt_q  <= '0;
            end else if (shift_q) begin
                if (mcnt_q == DW_C) begin
                    miso_q  <= 1'b0;
                    shift_q <= 1'b0;
`ifdef SPI_ADDR_AUTOINC_EN
                    rd_addr_q  <= rd_next;
`else
                    rd_valid_q <= 1'b0;
`endif
                end else begin
                    miso_q  <= shreg_q[DATA_WIDTH-1];
                    shreg_q <= {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    mcnt_q  <= mcnt_q + MCW'(1);
                end
            end
        end
    end

    assign MISO    = miso_q;
    assign cmd_err = cmd_err_q;

endmodule

// File: tb/tb_spi_ram_slave_p.sv
// Directed bench for spi_ram_slave_p: default, 16-bit and shallow-RAM instances.
// Expectations follow SPI_ADDR_AUTOINC_EN when the build defines it.
module tb_spi_ram_slave_p;

    localparam int ST_IDLE     = 0;
    localparam int ST_READ_ADD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] ss_n = 3'b111;
    logic [2:0] mosi = 3'b000;
    wire  [2:0] miso;
    wire  [2:0] cmd_err;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    spi_ram_slave_p u8 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n[0]), .MOSI(mosi[0]),
        .MISO(miso[0]), .cmd_err(cmd_err[0])
    );

    spi_ram_slave_p #(.DATA_WIDTH(16), .ADDR_WIDTH(10), .MEM_DEPTH(1024)) u16 (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n[1]), .MOSI(mosi[1]),
        .MISO(miso[1]), .cmd_err(cmd_err[1])
    );

    spi_ram_slave_p #(.DATA_WIDTH(8), .ADDR_WIDTH(5), .MEM_DEPTH(20)) us (
        .clk(clk), .rst_n(rst_n), .SS_n(ss_n[2]), .MOSI(mosi[2]),
        .MISO(miso[2]), .cmd_err(cmd_err[2])
    );

    task automatic do_reset();
        rst_n = 1'b0;
        ss_n  = 3'b111;
        mosi  = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Select, one routing bit, then nbits frame bits MSB first. Returns one negedge
    // after the last bit; SS_n released there unless hold (early: released with last bit).
    task automatic send(input int id, input int fl, input logic route, input logic [17:0] f,
                        input int nbits, input bit hold, input bit early);
        @(negedge clk);
        ss_n[id] = 1'b0;
        mosi[id] = 1'b0;
        @(negedge clk);
        mosi[id] = route;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            mosi[id] = f[fl-1-i];
            if (early && i == nbits - 1) ss_n[id] = 1'b1;
        end
        @(negedge clk);
        if (!hold) ss_n[id] = 1'b1;
    endtask

    // Collects the read-return bits after a held 11 frame, then deselects
    task automatic capture(input int id, input int dw, output logic [15:0] w, output logic tail);
        w = '0;
        @(negedge clk);
        @(negedge clk);
        for (int b = dw - 1; b >= 0; b--) begin
            @(negedge clk);
            w[b] = miso[id];
        end
        @(negedge clk);
        tail = miso[id];
        ss_n[id] = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (miso[i] !== 1'b0) $display("FAIL reset_miso[%0d] got %b want 0", i, miso[i]);
            else passed++;
            checks++;
            if (cmd_err[i] !== 1'b0) $display("FAIL reset_cmd_err[%0d] got %b want 0", i, cmd_err[i]);
            else passed++;
        end
        send(0, 10, 1'b1, 18'({2'b11, 8'h00}), 10, 1'b1, 1'b0);
        checks++;
        if (int'(u8.state_q) !== ST_READ_ADD)
            $display("FAIL reset_route got %0d want %0d", int'(u8.state_q), ST_READ_ADD);
        else passed++;
        @(negedge clk);
        checks++;
        if (cmd_err[0] !== 1'b1) $display("FAIL reset_err_pulse got %b want 1", cmd_err[0]);
        else passed++;
        ss_n[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_err[0] !== 1'b0) $display("FAIL reset_err_clear got %b want 0", cmd_err[0]);
        else passed++;
    endtask

    task automatic test_write();
        send(0, 10, 1'b0, 18'({2'b00, 8'h03}), 10, 1'b0, 1'b0);
        send(0, 10, 1'b0, 18'({2'b01, 8'hB7}), 10, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (u8.mem[3] !== 8'hB7) $display("FAIL write_mem3 got %h want b7", u8.mem[3]);
        else passed++;
        checks++;
        if (cmd_err[0] !== 1'b0) $display("FAIL write_no_err got %b want 0", cmd_err[0]);
        else passed++;
    endtask

    task automatic test_read();
        logic [15:0] w;
        logic        tail;
        send(0, 10, 1'b1, 18'({2'b10, 8'h03}), 10, 1'b0, 1'b0);
        send(0, 10, 1'b1, 18'({2'b11, 8'h00}), 10, 1'b1, 1'b0);
        capture(0, 8, w, tail);
        checks++;
        if (w[7:0] !== 8'hB7) $display("FAIL read_bits got %h want b7", w[7:0]);
        else passed++;
        checks++;
        if (tail !== 1'b0) $display("FAIL read_tail got %b want 0", tail);
        else passed++;
`ifdef SPI_ADDR_AUTOINC_EN
        send(0, 10, 1'b1, 18'({2'b11, 8'h00}), 10, 1'b1, 1'b0);
        capture(0, 8, w, tail);
        checks++;
        if (w[7:0] !== 8'h3C) $display("FAIL read_next got %h want 3c", w[7:0]);
        else passed++;
`else
        send(0, 10, 1'b1, 18'({2'b11, 8'h00}), 10, 1'b1, 1'b0);
        checks++;
        if (int'(u8.state_q) !== ST_READ_ADD)
            $display("FAIL read_alternate got %0d want %0d", int'(u8.state_q), ST_READ_ADD);
        else passed++;
        @(negedge clk);
        checks++;
        if (cmd_err[0] !== 1'b1) $display("FAIL read_alt_err got %b want 1", cmd_err[0]);
        else passed++;
        ss_n[0] = 1'b1;
`endif
    endtask

    task automatic test_cmd_err();
        logic [7:0] exp_wa;
`ifdef SPI_ADDR_AUTOINC_EN
        exp_wa = 8'h04;
`else
        exp_wa = 8'h03;
`endif
        send(0, 10, 1'b0, 18'({2'b10, 8'h07}), 10, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (cmd_err[0] !== 1'b1) $display("FAIL err_write_state got %b want 1", cmd_err[0]);
        else passed++;
        send(0, 10, 1'b1, 18'({2'b00, 8'h09}), 10, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (cmd_err[0] !== 1'b1) $display("FAIL err_read_state got %b want 1", cmd_err[0]);
        else passed++;
        checks++;
        if (u8.wr_addr_q !== exp_wa) $display("FAIL err_addr_kept got %h want %h", u8.wr_addr_q, exp_wa);
        else passed++;
    endtask

    task automatic test_simultaneous_rise();
        send(0, 10, 1'b0, 18'({2'b00, 8'h10}), 10, 1'b0, 1'b1);
        send(0, 10, 1'b0, 18'({2'b01, 8'h66}), 10, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (u8.mem[16] !== 8'h66) $display("FAIL rise_write got %h want 66", u8.mem[16]);
        else passed++;
    endtask

    task automatic test_abort();
        send(0, 10, 1'b0, 18'({2'b00, 8'h20}), 10, 1'b0, 1'b0);
        send(0, 10, 1'b0, 18'({2'b01, 8'hEE}), 5, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (int'(u8.state_q) !== ST_IDLE) $display("FAIL abort_idle got %0d want %0d", int'(u8.state_q), ST_IDLE);
        else passed++;
        @(negedge clk);
        checks++;
        if (cmd_err[0] !== 1'b0) $display("FAIL abort_no_err got %b want 0", cmd_err[0]);
        else passed++;
        checks++;
        if (u8.mem[32] !== 8'h11) $display("FAIL abort_mem got %h want 11", u8.mem[32]);
        else passed++;
        checks++;
        if (u8.wr_addr_q !== 8'h20) $display("FAIL abort_addr got %h want 20", u8.wr_addr_q);
        else passed++;
    endtask

    task automatic test_burst();
        logic [15:0] w;
        logic        tail;
        do_reset();
        send(0, 10, 1'b0, 18'({2'b00, 8'hFF}), 10, 1'b0, 1'b0);
        send(0, 10, 1'b0, 18'({2'b01, 8'hAA}), 10, 1'b0, 1'b0);
        send(0, 10, 1'b0, 18'({2'b01, 8'h55}), 10, 1'b0, 1'b0);
        @(negedge clk);
        send(0, 10, 1'b1, 18'({2'b10, 8'hFF}), 10, 1'b0, 1'b0);
        send(0, 10, 1'b1, 18'({2'b11, 8'h00}), 10, 1'b1, 1'b0);
        capture(0, 8, w, tail);
`ifdef SPI_ADDR_AUTOINC_EN
        checks++;
        if (u8.mem[255] !== 8'hAA) $display("FAIL burst_mem_ff got %h want aa", u8.mem[255]);
        else passed++;
        checks++;
        if (u8.mem[0] !== 8'h55) $display("FAIL burst_mem_00 got %h want 55", u8.mem[0]);
        else passed++;
        checks++;
        if (w[7:0] !== 8'hAA) $display("FAIL burst_read0 got %h want aa", w[7:0]);
        else passed++;
        send(0, 10, 1'b1, 18'({2'b11, 8'h00}), 10, 1'b1, 1'b0);
        capture(0, 8, w, tail);
        checks++;
        if (w[7:0] !== 8'h55) $display("FAIL burst_read1 got %h want 55", w[7:0]);
        else passed++;
`else
        checks++;
        if (u8.mem[255] !== 8'h55) $display("FAIL hold_mem_ff got %h want 55", u8.mem[255]);
        else passed++;
        checks++;
        if (w[7:0] !== 8'h55) $display("FAIL hold_read got %h want 55", w[7:0]);
        else passed++;
`endif
    endtask

    task automatic test_generic_width();
        logic [15:0] w;
        logic        tail;
        send(1, 18, 1'b0, {2'b00, 16'h03FF}, 18, 1'b0, 1'b0);
        send(1, 18, 1'b0, {2'b01, 16'hBEEF}, 18, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (u16.mem[1023] !== 16'hBEEF) $display("FAIL wide_mem got %h want beef", u16.mem[1023]);
        else passed++;
        send(1, 18, 1'b1, {2'b10, 16'h03FF}, 18, 1'b0, 1'b0);
        send(1, 18, 1'b1, {2'b11, 16'h0000}, 18, 1'b1, 1'b0);
        capture(1, 16, w, tail);
        checks++;
        if (w !== 16'hBEEF) $display("FAIL wide_read got %h want beef", w);
        else passed++;
        checks++;
        if (tail !== 1'b0) $display("FAIL wide_tail got %b want 0", tail);
        else passed++;
    endtask

    task automatic test_range();
        logic [15:0] w;
        logic        tail;
        send(2, 10, 1'b1, 18'({2'b10, 8'd19}), 10, 1'b0, 1'b0);
        send(2, 10, 1'b1, 18'({2'b11, 8'h00}), 10, 1'b1, 1'b0);
        capture(2, 8, w, tail);
        checks++;
        if (w[7:0] !== 8'h77) $display("FAIL range_last got %h want 77", w[7:0]);
        else passed++;
        do_reset();
        send(2, 10, 1'b0, 18'({2'b00, 8'd25}), 10, 1'b0, 1'b0);
        send(2, 10, 1'b0, 18'({2'b01, 8'h5A}), 10, 1'b0, 1'b0);
        send(2, 10, 1'b1, 18'({2'b10, 8'd25}), 10, 1'b0, 1'b0);
        send(2, 10, 1'b1, 18'({2'b11, 8'h00}), 10, 1'b1, 1'b0);
        capture(2, 8, w, tail);
        checks++;
        if (w[7:0] !== 8'h00) $display("FAIL range_oor_read got %h want 00", w[7:0]);
        else passed++;
        checks++;
        if (us.mem[19] !== 8'h77) $display("FAIL range_mem_kept got %h want 77", us.mem[19]);
        else passed++;
    endtask

    initial begin
        u8.mem[4]  = 8'h3C;
        u8.mem[32] = 8'h11;
        us.mem[19] = 8'h77;
        test_reset();
        test_write();
        test_read();
        test_cmd_err();
        test_simultaneous_rise();
        test_abort();
        test_burst();
        test_generic_width();
        test_range();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
